// File: rtl/conv_pipe.sv
`default_nettype none
// ============================================================================
// conv_pipe : 3-stage KWxKH window convolution with serially loaded signed
//             coefficients, rounded run-time right shift and pixel saturation.
// Revision  : 1.0
// ============================================================================
module conv_pipe #(
  parameter int KERNAL_WIDTH  = 3,
  parameter int KERNAL_HEIGHT = 3,
  parameter int COLOUR_DEPTH  = 8,
  parameter int COEF_WIDTH    = 8,
  parameter int SHIFT_WIDTH   = 5
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          k_load,
  input  logic [SHIFT_WIDTH-1:0]        k_shift,
  input  logic                          k_valid,
  input  logic signed [COEF_WIDTH-1:0]  k_data,
  output logic                          busy,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [COLOUR_DEPTH-1:0]       data_mat [KERNAL_WIDTH*KERNAL_HEIGHT],
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [COLOUR_DEPTH-1:0]       w_data
);

  localparam int N    = KERNAL_WIDTH * KERNAL_HEIGHT;
  localparam int CD   = COLOUR_DEPTH;
  localparam int PW   = COLOUR_DEPTH + COEF_WIDTH + 1;
  localparam int ACC  = PW + $clog2(N);
  localparam int RW   = ACC + 1;
  localparam int IDXW = (N > 1) ? $clog2(N) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;

  logic [1:0]                   r_state;
  logic [1:0]                   w_state_nxt;
  logic [IDXW-1:0]              r_idx;
  logic [SHIFT_WIDTH-1:0]       r_shift;
  logic signed [COEF_WIDTH-1:0] r_coef [N];

  logic                         r_v1;
  logic                         r_v2;
  logic signed [PW-1:0]         r_p [N];
  logic signed [ACC-1:0]        r_s;

  logic                         w_stall;
  logic                         w_en;
  logic                         w_kload_acc;
  logic signed [ACC-1:0]        w_sum;
  logic signed [RW-1:0]         w_q;
  logic signed [RW-1:0]         w_r;
  logic [CD-1:0]                w_sat;

  assign w_stall     = out_valid && !out_ready;
  assign w_en        = !w_stall;
  assign w_kload_acc = k_load && !r_v1 && !r_v2 && !out_valid;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_kload_acc)
      w_state_nxt = S_LOAD;
    else if (r_state == S_LOAD && k_valid && r_idx == IDXW'(N - 1))
      w_state_nxt = S_RUN;
  end

  always_comb begin
    in_ready = (r_state == S_RUN) && !w_stall;
    busy     = (r_state == S_LOAD) || r_v1 || r_v2 || out_valid;
  end

  // A same-cycle k_valid loses to an accepted k_load, so its word is dropped.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_idx   <= '0;
      r_shift <= '0;
      for (int i = 0; i < N; i++) r_coef[i] <= '0;
    end else if (w_kload_acc) begin
      r_idx   <= '0;
      r_shift <= k_shift;
    end else if (r_state == S_LOAD && k_valid) begin
      r_coef[r_idx] <= k_data;
      r_idx         <= (r_idx == IDXW'(N - 1)) ? '0 : r_idx + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_v1 <= 1'b0;
      for (int i = 0; i < N; i++) r_p[i] <= '0;
    end else if (w_en) begin
      r_v1 <= in_valid && in_ready;
      for (int i = 0; i < N; i++)
        r_p[i] <= PW'($signed({1'b0, data_mat[i]})) * PW'(r_coef[i]);
    end
  end

  always_comb begin
    w_sum = '0;
    for (int i = 0; i < N; i++) w_sum = w_sum + ACC'(r_p[i]);
  end

  // floor((s + 2^(k-1)) / 2^k) == ((s >>> (k-1)) + 1) >>> 1, which never overflows.
  always_comb begin
    w_q = RW'(r_s) >>> (r_shift - 1'b1);
    if (r_shift == '0) w_r = RW'(r_s);
    else               w_r = (w_q + RW'(1)) >>> 1;
    if (w_r[RW-1])             w_sat = '0;
    else if (|w_r[RW-2:CD])    w_sat = '1;
    else                       w_sat = w_r[CD-1:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_v2      <= 1'b0;
      r_s       <= '0;
      out_valid <= 1'b0;
      w_data    <= '0;
    end else if (w_en) begin
      r_v2      <= r_v1;
      r_s       <= w_sum;
      out_valid <= r_v2;
      w_data    <= w_sat;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_conv_pipe.sv
`default_nettype none
// ============================================================================
// tb_conv_pipe : directed + randomized bench with an arithmetic reference model.
// Revision     : 1.0
// ============================================================================
module tb_conv_pipe;

  localparam int N = 9;

  logic              clk = 1'b0;
  logic              reset;
  logic              k_load;
  logic [4:0]        k_shift;
  logic              k_valid;
  logic signed [7:0] k_data;
  logic              busy;
  logic              in_valid;
  logic              in_ready;
  logic [7:0]        data_mat [N];
  logic              out_valid;
  logic              out_ready;
  logic [7:0]        w_data;

  int         n_pass  = 0;
  int         n_total = 0;
  int         mcoef [N];
  int         mshift;
  int         cset  [N];
  logic [7:0] exp_q [$];
  int         cyc = 0, n_out = 0, n_acc = 0, first_cyc = 0, last_cyc = 0;
  int         out0, acc0;
  logic [7:0] last_out = 8'd0;
  logic [7:0] held;

  conv_pipe #(
    .KERNAL_WIDTH (3),
    .KERNAL_HEIGHT(3),
    .COLOUR_DEPTH (8),
    .COEF_WIDTH   (8),
    .SHIFT_WIDTH  (5)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .k_load   (k_load),
    .k_shift  (k_shift),
    .k_valid  (k_valid),
    .k_data   (k_data),
    .busy     (busy),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .data_mat (data_mat),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .w_data   (w_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_total++;
    assert (obs === expv) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  // Reference: exact dot product, round-half-up shift, clamp to 0..255.
  function automatic logic [7:0] model_px();
    longint s = 0;
    longint r;
    for (int i = 0; i < N; i++) s += longint'(data_mat[i]) * longint'(mcoef[i]);
    if (mshift == 0) r = s;
    else             r = (s + (longint'(1) << (mshift - 1))) >>> mshift;
    if (r < 0)   return 8'd0;
    if (r > 255) return 8'd255;
    return 8'(r);
  endfunction

  task automatic tick();
    @(negedge clk);
    if (out_valid === 1'b1 && out_ready) begin
      check("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) check("result", 32'(w_data), 32'(exp_q.pop_front()));
      if (n_out == 0) first_cyc = cyc;
      last_cyc = cyc;
      last_out = w_data;
      n_out++;
    end
    if (in_valid && in_ready === 1'b1) begin
      exp_q.push_back(model_px());
      n_acc++;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic rand_win();
    for (int i = 0; i < N; i++) data_mat[i] = 8'($urandom_range(0, 255));
  endtask

  task automatic fill_win(input int v);
    for (int i = 0; i < N; i++) data_mat[i] = 8'(v);
  endtask

  task automatic rand_coefs();
    for (int i = 0; i < N; i++) cset[i] = int'($urandom_range(0, 255)) - 128;
  endtask

  task automatic load(input int sh, input int nwords, input bit collide);
    k_load  = 1'b1;
    k_shift = 5'(sh);
    k_valid = collide;
    k_data  = 8'sd77;
    tick();
    k_load = 1'b0;
    for (int i = 0; i < nwords; i++) begin
      k_valid = 1'b1;
      k_data  = 8'(cset[i]);
      tick();
    end
    k_valid = 1'b0;
    if (nwords == N) begin
      mcoef  = cset;
      mshift = sh;
    end
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (6) tick();
  endtask

  initial begin
    reset = 1'b0; k_load = 1'b0; k_shift = '0; k_valid = 1'b0; k_data = '0;
    in_valid = 1'b0; out_ready = 1'b1; fill_win(0);
    for (int i = 0; i < N; i++) mcoef[i] = 0;
    mshift = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready",  32'(in_ready),  32'd0);
    check("rst_busy",      32'(busy),      32'd0);
    check("rst_w_data",    32'(w_data),    32'd0);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    check("idle_in_ready", 32'(in_ready), 32'd0);

    // Identity kernel and pipeline latency
    for (int i = 0; i < N; i++) cset[i] = 0;
    cset[4] = 1;
    load(0, N, 1'b0);
    check("id_busy",     32'(busy),     32'd0);
    check("id_in_ready", 32'(in_ready), 32'd1);
    rand_win(); data_mat[4] = 8'd200;
    in_valid = 1'b1; tick(); in_valid = 1'b0;
    check("lat_e1", 32'(out_valid), 32'd0);
    tick();
    check("lat_e2", 32'(out_valid), 32'd0);
    tick();
    check("lat_e3", 32'(out_valid), 32'd1);
    check("id_value", 32'(w_data), 32'd200);
    drain();

    // Box blur, 20 back-to-back windows
    for (int i = 0; i < N; i++) cset[i] = 1;
    load(3, N, 1'b0);
    fill_win(80);
    n_out = 0;
    in_valid = 1'b1;
    repeat (20) tick();
    drain();
    check("box_count", 32'(n_out), 32'd20);
    check("box_run",   32'(last_cyc - first_cyc), 32'd19);
    check("box_value", 32'(last_out), 32'd90);

    // Laplacian saturation at both ends
    for (int i = 0; i < N; i++) cset[i] = -1;
    cset[4] = 8;
    load(0, N, 1'b0);
    fill_win(255); data_mat[4] = 8'd0;
    in_valid = 1'b1; tick(); drain();
    check("lap_low", 32'(last_out), 32'd0);
    fill_win(0); data_mat[4] = 8'd255;
    in_valid = 1'b1; tick(); drain();
    check("lap_high", 32'(last_out), 32'd255);

    // k_load and k_valid together: the colliding word must be discarded
    rand_coefs();
    load(int'($urandom_range(0, 9)), N, 1'b1);
    for (int c = 0; c < 40; c++) begin
      rand_win();
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    drain();
    check("collide_sb_empty", 32'(exp_q.size()), 32'd0);

    // Only N-1 words: stays in LOAD
    rand_coefs();
    load(2, N - 1, 1'b0);
    in_valid = 1'b1; rand_win();
    tick(); tick();
    check("part_in_ready", 32'(in_ready), 32'd0);
    check("part_busy",     32'(busy),     32'd1);
    k_valid = 1'b1; k_data = 8'(cset[N-1]);
    tick();
    k_valid = 1'b0;
    mcoef = cset; mshift = 2;
    check("part_run", 32'(in_ready), 32'd1);
    repeat (10) begin rand_win(); tick(); end
    drain();
    check("part_sb_empty", 32'(exp_q.size()), 32'd0);

    // Backpressure: five stalled cycles mid-stream
    rand_coefs();
    load(4, N, 1'b0);
    out0 = n_out; acc0 = n_acc;
    in_valid = 1'b1; out_ready = 1'b1;
    repeat (6) begin rand_win(); tick(); end
    out_ready = 1'b0; rand_win(); tick();
    held = w_data;
    repeat (5) begin
      check("bp_in_ready",  32'(in_ready),  32'd0);
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_hold",      32'(w_data),    32'(held));
      rand_win(); tick();
    end
    drain();
    check("bp_sb_empty", 32'(exp_q.size()), 32'd0);
    check("bp_count",    32'(n_out - out0), 32'(n_acc - acc0));

    // k_load while the pipeline holds data is ignored
    in_valid = 1'b1; rand_win(); tick(); rand_win(); tick();
    check("kl_busy", 32'(busy), 32'd1);
    k_load = 1'b1; k_shift = 5'd9; rand_win(); tick(); k_load = 1'b0;
    repeat (3) begin rand_win(); tick(); end
    drain();
    check("kl_still_run", 32'(in_ready), 32'd1);
    check("kl_sb_empty",  32'(exp_q.size()), 32'd0);

    // Randomized traffic
    rand_coefs();
    load(int'($urandom_range(0, 12)), N, 1'b0);
    for (int c = 0; c < 300; c++) begin
      rand_win();
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    drain();
    check("rand_sb_empty", 32'(exp_q.size()), 32'd0);

    // Asynchronous reset in LOAD at idx 4, then reload
    rand_coefs();
    load(1, 4, 1'b0);
    #2 reset = 1'b0;
    #1;
    check("rl_out_valid", 32'(out_valid), 32'd0);
    check("rl_busy",      32'(busy),      32'd0);
    check("rl_in_ready",  32'(in_ready),  32'd0);
    exp_q.delete();
    for (int i = 0; i < N; i++) mcoef[i] = 0;
    mshift = 0;
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < N; i++) cset[i] = 0;
    cset[4] = 1;
    load(0, N, 1'b0);
    rand_win(); data_mat[4] = 8'd200;
    in_valid = 1'b1; tick(); drain();
    check("rl_identity", 32'(last_out), 32'd200);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
